// File: rtl/simd_upstream_packer_if.sv
// simd_upstream_packer_if
//   Upstream beat bus between the SIMD upstream packer (master) and the
//   network stack (slave).
//   Signals:
//     sui__sti__valid     beat valid (master -> slave)
//     sti__sui__ready     slave accepts the beat this cycle (slave -> master)
//     sui__sti__cntl      SOM 2'b01, MOM 2'b00, EOM 2'b10, SOM_EOM 2'b11
//     sui__sti__type      DATA 2'b01 on the first beat, NA 2'b00 otherwise
//     sui__sti__data      beat payload, BUS_WIDTH bits
//     sui__sti__oob_data  message tag, repeated on every beat
interface simd_upstream_packer_if #(
  parameter int unsigned BUS_WIDTH = 64,
  parameter int unsigned TAG_WIDTH = 8
) ();

  logic                 sui__sti__valid;
  logic                 sti__sui__ready;
  logic [1:0]           sui__sti__cntl;
  logic [1:0]           sui__sti__type;
  logic [BUS_WIDTH-1:0] sui__sti__data;
  logic [TAG_WIDTH-1:0] sui__sti__oob_data;

  modport master (
    output sui__sti__valid,
    input  sti__sui__ready,
    output sui__sti__cntl,
    output sui__sti__type,
    output sui__sti__data,
    output sui__sti__oob_data
  );

  modport slave (
    input  sui__sti__valid,
    output sti__sui__ready,
    input  sui__sti__cntl,
    input  sui__sti__type,
    input  sui__sti__data,
    input  sui__sti__oob_data
  );

endinterface

// File: rtl/simd_upstream_packer.sv
// simd_upstream_packer
//   Packs the active SIMD lane registers into BUS_WIDTH beats and queues them
//   in an output FIFO towards the network stack.
//   Ports:
//     clk                       sole clock, rising edge
//     reset_poweron_n           synchronous, active-low reset
//     peId                      PE identifier (informational only)
//     cfg__sui__lane_mask       active-lane mask
//     simd__sui__tag            message tag
//     simd__sui__regs_valid     per-lane register valid
//     simd__sui__regs           lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//     sui__simd__regs_ready     packer idle, can accept a message
//     sui__simd__regs_complete  message fully queued; SIMD may clear valids
//     sti                       upstream beat bus (master side)
module simd_upstream_packer #(
  parameter int unsigned NUM_LANES      = 32,
  parameter int unsigned LANE_WIDTH     = 32,
  parameter int unsigned BUS_WIDTH      = 64,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_THRESHOLD = 2,
  parameter int unsigned PE_ID_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            reset_poweron_n,
  input  logic [PE_ID_WIDTH-1:0]          peId,
  input  logic [NUM_LANES-1:0]            cfg__sui__lane_mask,
  input  logic [TAG_WIDTH-1:0]            simd__sui__tag,
  input  logic [NUM_LANES-1:0]            simd__sui__regs_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] simd__sui__regs,
  output logic                            sui__simd__regs_ready,
  output logic                            sui__simd__regs_complete,
  simd_upstream_packer_if.master          sti
);

  localparam int unsigned LPB        = BUS_WIDTH / LANE_WIDTH;
  localparam int unsigned LPB_LOG2   = (LPB > 1) ? $clog2(LPB) : 0;
  localparam int unsigned NUM_BEATS  = NUM_LANES / LPB;
  localparam int unsigned BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W    = 4 + TAG_WIDTH + BUS_WIDTH;

  typedef enum logic [1:0] {StWait, StSend, StComplete} state_e;

  // Informational input; not used by the datapath.
  logic unused_pe_id;
  assign unused_pe_id = ^peId;

  // ---------------------------------------------------------------------------
  // Input registers (d1)
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0]            mask_d1;
  logic [TAG_WIDTH-1:0]            tag_d1;
  logic [NUM_LANES-1:0]            valid_d1;
  logic [NUM_LANES*LANE_WIDTH-1:0] regs_d1;

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      mask_d1  <= '0;
      tag_d1   <= '0;
      valid_d1 <= '0;
      regs_d1  <= '0;
    end else begin
      mask_d1  <= cfg__sui__lane_mask;
      tag_d1   <= simd__sui__tag;
      valid_d1 <= simd__sui__regs_valid;
      regs_d1  <= simd__sui__regs;
    end
  end

  // ---------------------------------------------------------------------------
  // Active-set decode on the d1 inputs
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] masked_lanes;
  logic [NUM_BEATS-1:0][BUS_WIDTH-1:0]  masked_beats;
  logic [LANE_IDX_W-1:0]                msb_d1;
  logic [BEAT_W-1:0]                    last_d1;
  logic                                 all_ready;

  // Zero inactive lanes up front so every beat is a plain slice later.
  always_comb begin
    masked_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_d1[i]) masked_lanes[i] = regs_d1[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign masked_beats = masked_lanes;

  always_comb begin
    msb_d1 = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_d1[i]) msb_d1 = LANE_IDX_W'(i);
    end
  end

  // Index of the final beat, i.e. beat count minus one.
  assign last_d1   = BEAT_W'(msb_d1 >> LPB_LOG2);
  assign all_ready = (mask_d1 != '0) && ((valid_d1 & mask_d1) == mask_d1);

  // ---------------------------------------------------------------------------
  // Message snapshot, taken when the message is accepted
  // ---------------------------------------------------------------------------
  logic [NUM_BEATS-1:0][BUS_WIDTH-1:0] snap_beats_q;
  logic [TAG_WIDTH-1:0]                snap_tag_q;
  logic [NUM_LANES-1:0]                snap_mask_q;
  logic [BEAT_W-1:0]                   snap_last_q;
  logic                                capture;

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      snap_beats_q <= '0;
      snap_tag_q   <= '0;
      snap_mask_q  <= '0;
      snap_last_q  <= '0;
    end else if (capture) begin
      snap_beats_q <= masked_beats;
      snap_tag_q   <= tag_d1;
      snap_mask_q  <= mask_d1;
      snap_last_q  <= last_d1;
    end
  end

  // COMPLETE waits on the lanes of the in-flight message, not the live mask.
  logic active_pending;
  assign active_pending = |(valid_d1 & snap_mask_q);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ready_q, complete_q;
  logic                almost_full;
  logic                wr_en;
  logic [BEAT_W-1:0]   wr_beat;
  logic [BEAT_W-1:0]   wr_last;
  logic [BUS_WIDTH-1:0] wr_data;
  logic [TAG_WIDTH-1:0] wr_tag;

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      state_q    <= StWait;
      beat_q     <= '0;
      ready_q    <= 1'b1;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      ready_q    <= (state_d == StWait);
      complete_q <= (state_d == StComplete);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    capture = 1'b0;
    wr_en   = 1'b0;
    wr_beat = beat_q;
    wr_last = snap_last_q;
    wr_data = snap_beats_q[beat_q];
    wr_tag  = snap_tag_q;
    unique case (state_q)
      StWait: begin
        // Beat 0 comes straight from the d1 registers in the capture cycle.
        if (all_ready && !almost_full) begin
          capture = 1'b1;
          wr_en   = 1'b1;
          wr_beat = '0;
          wr_last = last_d1;
          wr_data = masked_beats[0];
          wr_tag  = tag_d1;
          beat_d  = BEAT_W'(1);
          state_d = (last_d1 == '0) ? StComplete : StSend;
        end
      end
      StSend: begin
        if (!almost_full) begin
          wr_en = 1'b1;
          if (beat_q == snap_last_q) begin
            state_d = StComplete;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StComplete: begin
        if (!active_pending) state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  assign sui__simd__regs_ready    = ready_q;
  assign sui__simd__regs_complete = complete_q;

  // ---------------------------------------------------------------------------
  // Output FIFO: entry = {cntl, type, tag, data}
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fifo_empty;
  logic               rd_en;
  logic [1:0]         wr_cntl, wr_type;
  logic [ENTRY_W-1:0] wr_entry, head;

  assign wr_cntl  = {wr_beat == wr_last, wr_beat == '0};
  assign wr_type  = (wr_beat == '0) ? 2'b01 : 2'b00;
  assign wr_entry = {wr_cntl, wr_type, wr_tag, wr_data};

  assign fifo_empty  = (count_q == '0);
  // Headroom of FIFO_THRESHOLD entries means a write never lands on a full FIFO.
  assign almost_full = (count_q >= CNT_W'(FIFO_DEPTH - FIFO_THRESHOLD));
  assign rd_en       = !fifo_empty && sti.sti__sui__ready;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign sti.sui__sti__valid    = !fifo_empty;
  assign sti.sui__sti__cntl     = head[ENTRY_W-1 -: 2];
  assign sti.sui__sti__type     = head[ENTRY_W-3 -: 2];
  assign sti.sui__sti__oob_data = head[BUS_WIDTH +: TAG_WIDTH];
  assign sti.sui__sti__data     = head[BUS_WIDTH-1:0];

endmodule
